cart_mem_arbiter: RTL and testbench
===================================

Name: cart_mem_arbiter

Overview:
- Shares one external cartridge memory port between the CPU side (PRG ROM / PRG RAM) and the PPU side (CHR ROM/RAM).
- Sits between the active mapper's extended-address outputs and the board memory controller.
- Packs the three address spaces into one flat 21-bit byte address map.
- Arbitrates between the two sides, tracks in-flight reads and routes each returned byte to the requester that issued it.

Parameters:
- PPU_PRIORITY, 1: 1 = PPU wins every conflict; 0 = round-robin.
- TAG_DEPTH, 2: depth of the in-flight read tag FIFO (power of two, ≥2).

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  reset; synchronous, active-low
- cpu_req_i  in  1  CPU access request, level, held until cpu_ack_o
- cpu_sel_ram_i  in  1  0 = PRG ROM, 1 = PRG RAM
- cpu_we_i  in  1  write enable (honoured for PRG RAM only)
- cpu_rom_addr_i  in  19  mapper PRG ROM address
- cpu_ram_addr_i  in  15  mapper PRG RAM address
- cpu_wdata_i  in  8  write data
- cpu_rdata_o  out  8  read data, valid with cpu_ack_o
- cpu_ack_o  out  1  one-cycle completion pulse
- ppu_req_i  in  1  CHR access request, level
- ppu_we_i  in  1  CHR RAM write
- ppu_addr_i  in  18  mapper CHR address
- ppu_wdata_i  in  8  write data
- ppu_rdata_o  out  8  read data, valid with ppu_ack_o
- ppu_ack_o  out  1  one-cycle completion pulse
- mem_req_o  out  1  memory command valid
- mem_we_o  out  1  memory write
- mem_addr_o  out  21  flat byte address
- mem_wdata_o  out  8  memory write data
- mem_ready_i  in  1  command accepted when mem_req_o & mem_ready_i
- mem_rvalid_i  in  1  read data valid; returns are in order
- mem_rdata_i  in  8  read data
- proto_err_o  out  1  sticky protocol error flag

Behaviour:
- Reset (rst_n_i low at a clock edge):
  - Every output is 0.
  - Both requester FSMs return to IDLE.
  - Tag FIFO is emptied and the round-robin pointer is set to favour the CPU.
  - In-flight reads are abandoned; any mem_rvalid_i arriving after reset hits an empty FIFO, is dropped and sets proto_err_o.
- Address map:
  - PRG ROM = {2'b00, rom[18:0]}
  - CHR = {3'b100, chr[17:0]}
  - PRG RAM = {6'b110000, ram[14:0]}
- A CPU write with cpu_sel_ram_i=0 (ROM) is not issued to memory; cpu_ack_o pulses on the next cycle.
- Per-requester FSM: IDLE -> PEND on req_i.
  - PEND -> IDLE on grant of a write (ack pulses in the acceptance cycle + 1).
  - PEND -> WAIT on grant of a read.
  - WAIT -> IDLE on the matching rvalid; ack and rdata are registered and appear one cycle after mem_rvalid_i.
- At most one outstanding access per requester.
  - A requester deasserts req_i or re-arms it in the cycle after ack.
  - req_i is only sampled in IDLE.
- Command register:
  - mem_req_o/addr/we/wdata are registered and held stable while mem_req_o=1 and mem_ready_i=0.
  - The next grant may load in the same cycle an acceptance occurs, giving back-to-back commands.
- Arbitration, both sides in PEND with the command register free:
  - PPU_PRIORITY=1: PPU is granted.
  - PPU_PRIORITY=0: the side not granted last is granted; the pointer updates on every grant.
- Tag FIFO:
  - Pushes the requester id on each accepted read and pops on mem_rvalid_i.
  - Push and pop in the same cycle are both legal.
  - A push when full cannot occur by construction; assert in simulation.
  - mem_rvalid_i with the FIFO empty sets proto_err_o, which clears only on reset.
- Latency, idle arbiter with mem_ready_i=1:
  - req at cycle 0 -> mem_req_o at cycle 1.
  - Write ack at cycle 2.
  - Read ack = rvalid cycle + 1.

Decomposition:
- Shared package/header holds:
  - requester id constants (REQ_CPU=0, REQ_PPU=1)
  - address-region prefix constants
  - FSM state encodings (IDLE/PEND/WAIT)
- One sub-module: cart_tag_fifo, a small synchronous FIFO of requester ids with push/pop/empty/full.

Test Plan:
- CPU ROM read at rom=19'h12345, memory returns 8'hA5 two cycles after accept -> mem_addr_o=21'h012345, cpu_rdata_o=8'hA5 with a single cpu_ack_o pulse.
- CPU and PPU requests raised in the same cycle, PPU_PRIORITY=0, three repeats -> grants alternate CPU, PPU, CPU…; with PPU_PRIORITY=1, PPU is always granted first.
- PPU CHR write chr=18'h3FFFF, data 8'h5A, mem_ready_i low for 3 cycles -> command held stable, mem_addr_o=21'h13FFFF, ppu_ack_o exactly once, cycle after accept.
- CPU read then PPU read back-to-back, returns 8'h11 then 8'h22 -> cpu_rdata_o=8'h11, ppu_rdata_o=8'h22, no cross-routing.
- Reset asserted while a read is in flight, stray mem_rvalid_i afterwards -> no ack, proto_err_o=1; all other outputs 0 during reset.
- CPU write with cpu_sel_ram_i=0 -> no mem_req_o, cpu_ack_o on the next cycle; same write with cpu_sel_ram_i=1, ram=15'h7FFF -> mem_addr_o=21'h187FFF.

Source files
------------

// File: rtl/cart_mem_arbiter_pkg.sv
// Shared constants and types for the cartridge memory arbiter: requester ids,
// flat address map prefixes, requester FSM states and the memory command word.
package cart_mem_arbiter_pkg;

    localparam int ADDR_W = 21;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_PPU = 1'b1;

    localparam logic [1:0] PRG_ROM_PFX = 2'b00;
    localparam logic [2:0] CHR_PFX     = 3'b100;
    localparam logic [5:0] PRG_RAM_PFX = 6'b110000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_WAIT = 2'd2
    } req_st_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        wdata;
    } mem_cmd_t;

    function automatic logic [ADDR_W-1:0] prg_addr(input logic sel_ram,
                                                   input logic [18:0] rom,
                                                   input logic [14:0] ram);
        return sel_ram ? {PRG_RAM_PFX, ram} : {PRG_ROM_PFX, rom};
    endfunction

    function automatic logic [ADDR_W-1:0] chr_addr(input logic [17:0] chr);
        return {CHR_PFX, chr};
    endfunction

endpackage

// File: rtl/cart_mem_arbiter_if.sv
// CPU, PPU and board-memory signals of the arbiter. Directions in signal names
// are from the arbiter's point of view; master is the arbiter, slave the board.
interface cart_mem_arbiter_if;

    logic        cpu_req_i;
    logic        cpu_sel_ram_i;
    logic        cpu_we_i;
    logic [18:0] cpu_rom_addr_i;
    logic [14:0] cpu_ram_addr_i;
    logic [7:0]  cpu_wdata_i;
    logic [7:0]  cpu_rdata_o;
    logic        cpu_ack_o;

    logic        ppu_req_i;
    logic        ppu_we_i;
    logic [17:0] ppu_addr_i;
    logic [7:0]  ppu_wdata_i;
    logic [7:0]  ppu_rdata_o;
    logic        ppu_ack_o;

    logic        mem_req_o;
    logic        mem_we_o;
    logic [20:0] mem_addr_o;
    logic [7:0]  mem_wdata_o;
    logic        mem_ready_i;
    logic        mem_rvalid_i;
    logic [7:0]  mem_rdata_i;

    logic        proto_err_o;

    modport master (
        input  cpu_req_i, cpu_sel_ram_i, cpu_we_i, cpu_rom_addr_i, cpu_ram_addr_i, cpu_wdata_i,
        output cpu_rdata_o, cpu_ack_o,
        input  ppu_req_i, ppu_we_i, ppu_addr_i, ppu_wdata_i,
        output ppu_rdata_o, ppu_ack_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_ready_i, mem_rvalid_i, mem_rdata_i,
        output proto_err_o
    );

    modport slave (
        output cpu_req_i, cpu_sel_ram_i, cpu_we_i, cpu_rom_addr_i, cpu_ram_addr_i, cpu_wdata_i,
        input  cpu_rdata_o, cpu_ack_o,
        output ppu_req_i, ppu_we_i, ppu_addr_i, ppu_wdata_i,
        input  ppu_rdata_o, ppu_ack_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_ready_i, mem_rvalid_i, mem_rdata_i,
        input  proto_err_o
    );

endinterface

// File: rtl/cart_tag_fifo.sv
// In-flight read tag FIFO: holds the requester id of each accepted read so
// in-order memory returns can be routed back to whoever issued them.
module cart_tag_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic push_i,
    input  logic push_id_i,
    input  logic pop_i,
    output logic pop_id_o,
    output logic empty_o,
    output logic full_o
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PW:0]      wr_q, wr_d, rd_q, rd_d;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push_i) begin
            mem_d[wr_q[PW-1:0]] = push_id_i;
            wr_d                = wr_q + (PW+1)'(1);
        end
        if (pop_i) begin
            rd_d = rd_q + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
        end
    end

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty_o  = (wr_q == rd_q);
    assign full_o   = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign pop_id_o = mem_q[rd_q[PW-1:0]];

endmodule

// File: rtl/cart_mem_arbiter.sv
// Shares the cartridge memory port between the CPU (PRG ROM/RAM) and PPU (CHR)
// sides: flat address packing, arbitration, command register and read routing.
module cart_mem_arbiter
    import cart_mem_arbiter_pkg::*;
#(
    parameter bit PPU_PRIORITY = 1'b1,
    parameter int TAG_DEPTH    = 2
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    cart_mem_arbiter_if.master bus
);

    req_st_e    st_q [2];
    req_st_e    st_d [2];
    logic [7:0] rdata_q [2];
    logic [7:0] rdata_d [2];
    logic [1:0] ack_q, ack_d;
    logic       cmd_vld_q, cmd_vld_d;
    mem_cmd_t   cmd_q, cmd_d;
    logic       cmd_id_q, cmd_id_d;
    logic       rr_last_q, rr_last_d;
    logic       err_q, err_d;

    logic [1:0] req, loaded, want;
    logic       cpu_rom_wr, accept, grant;
    logic       tag_push, tag_pop, tag_id, tag_empty, tag_full;

    assign req        = {bus.ppu_req_i, bus.cpu_req_i};
    assign cpu_rom_wr = bus.cpu_we_i & ~bus.cpu_sel_ram_i;
    assign accept     = cmd_vld_q & bus.mem_ready_i;
    assign tag_push   = accept & ~cmd_q.we;
    assign tag_pop    = bus.mem_rvalid_i & ~tag_empty;
    assign loaded     = {cmd_vld_q & cmd_id_q, cmd_vld_q & ~cmd_id_q};

    // A requester competes while pending and not already sitting in the command
    // register; req is ignored during the ack cycle since it is still held high.
    assign want[REQ_CPU] = (st_q[REQ_CPU] == ST_PEND && !loaded[REQ_CPU])
                        || (st_q[REQ_CPU] == ST_IDLE && req[REQ_CPU] && !ack_q[REQ_CPU] && !cpu_rom_wr);
    assign want[REQ_PPU] = (st_q[REQ_PPU] == ST_PEND && !loaded[REQ_PPU])
                        || (st_q[REQ_PPU] == ST_IDLE && req[REQ_PPU] && !ack_q[REQ_PPU]);

    always_comb begin
        if (want[REQ_CPU] && want[REQ_PPU]) begin
            grant = PPU_PRIORITY ? REQ_PPU : ~rr_last_q;
        end else begin
            grant = want[REQ_PPU];
        end
    end

    always_comb begin
        st_d      = st_q;
        rdata_d   = rdata_q;
        ack_d     = '0;
        cmd_vld_d = cmd_vld_q;
        cmd_d     = cmd_q;
        cmd_id_d  = cmd_id_q;
        rr_last_d = rr_last_q;
        err_d     = err_q | (bus.mem_rvalid_i & tag_empty);

        for (int r = 0; r < 2; r++) begin
            if (st_q[r] == ST_IDLE && req[r] && !ack_q[r]) st_d[r] = ST_PEND;
        end

        // Writes to PRG ROM never reach memory; they just complete.
        if (st_q[REQ_CPU] == ST_IDLE && bus.cpu_req_i && !ack_q[REQ_CPU] && cpu_rom_wr) begin
            st_d[REQ_CPU]  = ST_IDLE;
            ack_d[REQ_CPU] = 1'b1;
        end

        if (accept) begin
            cmd_vld_d = 1'b0;
            if (cmd_q.we) begin
                st_d[cmd_id_q]  = ST_IDLE;
                ack_d[cmd_id_q] = 1'b1;
            end else begin
                st_d[cmd_id_q] = ST_WAIT;
            end
        end

        if (tag_pop) begin
            st_d[tag_id]    = ST_IDLE;
            ack_d[tag_id]   = 1'b1;
            rdata_d[tag_id] = bus.mem_rdata_i;
        end

        if ((!cmd_vld_q || accept) && want != 2'b00) begin
            cmd_vld_d = 1'b1;
            cmd_id_d  = grant;
            rr_last_d = grant;
            if (grant == REQ_PPU) begin
                cmd_d = '{we: bus.ppu_we_i, addr: chr_addr(bus.ppu_addr_i), wdata: bus.ppu_wdata_i};
            end else begin
                cmd_d = '{we:    bus.cpu_we_i & bus.cpu_sel_ram_i,
                          addr:  prg_addr(bus.cpu_sel_ram_i, bus.cpu_rom_addr_i, bus.cpu_ram_addr_i),
                          wdata: bus.cpu_wdata_i};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            st_q      <= '{default: ST_IDLE};
            rdata_q   <= '{default: 8'h00};
            ack_q     <= '0;
            cmd_vld_q <= 1'b0;
            cmd_q     <= '0;
            cmd_id_q  <= REQ_CPU;
            rr_last_q <= REQ_PPU;
            err_q     <= 1'b0;
        end else begin
            st_q      <= st_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
            cmd_vld_q <= cmd_vld_d;
            cmd_q     <= cmd_d;
            cmd_id_q  <= cmd_id_d;
            rr_last_q <= rr_last_d;
            err_q     <= err_d;
        end
    end

    cart_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .push_i    (tag_push),
        .push_id_i (cmd_id_q),
        .pop_i     (tag_pop),
        .pop_id_o  (tag_id),
        .empty_o   (tag_empty),
        .full_o    (tag_full)
    );

    // One outstanding access per requester keeps the FIFO from overflowing.
    tag_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
                                      !(tag_push && tag_full && !tag_pop));

    assign bus.mem_req_o   = cmd_vld_q;
    assign bus.mem_we_o    = cmd_q.we;
    assign bus.mem_addr_o  = cmd_q.addr;
    assign bus.mem_wdata_o = cmd_q.wdata;
    assign bus.cpu_ack_o   = ack_q[REQ_CPU];
    assign bus.ppu_ack_o   = ack_q[REQ_PPU];
    assign bus.cpu_rdata_o = rdata_q[REQ_CPU];
    assign bus.ppu_rdata_o = rdata_q[REQ_PPU];
    assign bus.proto_err_o = err_q;

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Directed bench: a round-robin arbiter (b) and a PPU-priority arbiter (p) see
// identical stimulus; outputs are sampled on the falling edge.
module tb_cart_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    cart_mem_arbiter_if b();
    cart_mem_arbiter_if p();

    assign p.cpu_req_i      = b.cpu_req_i;
    assign p.cpu_sel_ram_i  = b.cpu_sel_ram_i;
    assign p.cpu_we_i       = b.cpu_we_i;
    assign p.cpu_rom_addr_i = b.cpu_rom_addr_i;
    assign p.cpu_ram_addr_i = b.cpu_ram_addr_i;
    assign p.cpu_wdata_i    = b.cpu_wdata_i;
    assign p.ppu_req_i      = b.ppu_req_i;
    assign p.ppu_we_i       = b.ppu_we_i;
    assign p.ppu_addr_i     = b.ppu_addr_i;
    assign p.ppu_wdata_i    = b.ppu_wdata_i;
    assign p.mem_ready_i    = b.mem_ready_i;
    assign p.mem_rvalid_i   = b.mem_rvalid_i;
    assign p.mem_rdata_i    = b.mem_rdata_i;

    cart_mem_arbiter #(.PPU_PRIORITY(1'b0), .TAG_DEPTH(2)) dut_rr (
        .clk_i(clk), .rst_n_i(rst_n), .bus(b));
    cart_mem_arbiter #(.PPU_PRIORITY(1'b1), .TAG_DEPTH(2)) dut_pp (
        .clk_i(clk), .rst_n_i(rst_n), .bus(p));

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle_inputs();
        b.cpu_req_i = 0; b.cpu_sel_ram_i = 0; b.cpu_we_i = 0;
        b.ppu_req_i = 0; b.ppu_we_i = 0;
        b.mem_rvalid_i = 0;
    endtask

    // CPU RAM write and PPU CHR write raised together.
    task automatic pair(input string tag, input logic rr_ppu_first);
        b.cpu_req_i = 1; b.cpu_sel_ram_i = 1; b.cpu_we_i = 1;
        b.cpu_ram_addr_i = 15'h0001; b.cpu_wdata_i = 8'hC1;
        b.ppu_req_i = 1; b.ppu_we_i = 1; b.ppu_addr_i = 18'h00002; b.ppu_wdata_i = 8'hD2;
        tick();
        chk({tag, "_rr_first"}, b.mem_addr_o, rr_ppu_first ? 21'h100002 : 21'h180001);
        chk({tag, "_pp_first"}, p.mem_addr_o, 21'h100002);
        tick();
        chk({tag, "_rr_second"}, b.mem_addr_o, rr_ppu_first ? 21'h180001 : 21'h100002);
        chk({tag, "_pp_second"}, p.mem_addr_o, 21'h180001);
        chk({tag, "_rr_ack1"}, {b.cpu_ack_o, b.ppu_ack_o}, rr_ppu_first ? 2'b01 : 2'b10);
        tick();
        chk({tag, "_rr_ack2"}, {b.cpu_ack_o, b.ppu_ack_o}, rr_ppu_first ? 2'b10 : 2'b01);
        chk({tag, "_rr_idle"}, b.mem_req_o, 0);
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        b.cpu_rom_addr_i = '0; b.cpu_ram_addr_i = '0; b.cpu_wdata_i = '0;
        b.ppu_addr_i = '0; b.ppu_wdata_i = '0;
        b.mem_ready_i = 1; b.mem_rdata_i = '0;
        rst_n = 0;
        tick(); tick(); tick();
        chk("rst_mem_req", b.mem_req_o, 0);
        chk("rst_addr", b.mem_addr_o, 0);
        chk("rst_acks", {b.cpu_ack_o, b.ppu_ack_o}, 0);
        chk("rst_err", b.proto_err_o, 0);
        rst_n = 1;
        tick();

        // CPU ROM read, data returned two cycles after acceptance
        b.cpu_req_i = 1; b.cpu_rom_addr_i = 19'h12345;
        tick();
        chk("rd_mem_req", b.mem_req_o, 1);
        chk("rd_addr", b.mem_addr_o, 21'h012345);
        chk("rd_we", b.mem_we_o, 0);
        tick();
        chk("rd_cmd_done", b.mem_req_o, 0);
        tick();
        chk("rd_no_early_ack", b.cpu_ack_o, 0);
        b.mem_rvalid_i = 1; b.mem_rdata_i = 8'hA5;
        tick();
        chk("rd_ack", b.cpu_ack_o, 1);
        chk("rd_data", b.cpu_rdata_o, 8'hA5);
        idle_inputs();
        tick();
        chk("rd_ack_single", b.cpu_ack_o, 0);

        // PPU CHR write held off by mem_ready_i for three cycles
        b.mem_ready_i = 0;
        b.ppu_req_i = 1; b.ppu_we_i = 1; b.ppu_addr_i = 18'h3FFFF; b.ppu_wdata_i = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_req", b.mem_req_o, 1);
            chk("stall_addr", b.mem_addr_o, 21'h13FFFF);
            chk("stall_wdata", b.mem_wdata_o, 8'h5A);
            chk("stall_we", b.mem_we_o, 1);
            chk("stall_no_ack", b.ppu_ack_o, 0);
        end
        b.mem_ready_i = 1;
        tick();
        chk("stall_ack", b.ppu_ack_o, 1);
        chk("stall_cmd_done", b.mem_req_o, 0);
        idle_inputs();
        tick();
        chk("stall_ack_single", b.ppu_ack_o, 0);

        // CPU read then PPU read back-to-back, in-order returns
        b.cpu_req_i = 1; b.cpu_sel_ram_i = 0; b.cpu_rom_addr_i = 19'h00010;
        b.ppu_req_i = 1; b.ppu_we_i = 0; b.ppu_addr_i = 18'h00020;
        tick();
        chk("b2b_cpu_addr", b.mem_addr_o, 21'h000010);
        tick();
        chk("b2b_ppu_addr", b.mem_addr_o, 21'h100020);
        tick();
        chk("b2b_cmd_done", b.mem_req_o, 0);
        b.mem_rvalid_i = 1; b.mem_rdata_i = 8'h11;
        tick();
        chk("b2b_cpu_ack", {b.cpu_ack_o, b.ppu_ack_o}, 2'b10);
        chk("b2b_cpu_data", b.cpu_rdata_o, 8'h11);
        b.mem_rdata_i = 8'h22; b.cpu_req_i = 0;
        tick();
        chk("b2b_ppu_ack", {b.cpu_ack_o, b.ppu_ack_o}, 2'b01);
        chk("b2b_ppu_data", b.ppu_rdata_o, 8'h22);
        chk("b2b_cpu_kept", b.cpu_rdata_o, 8'h11);
        chk("b2b_no_err", b.proto_err_o, 0);
        idle_inputs();
        tick();

        // Reset with a read in flight, then a stray return
        b.cpu_req_i = 1; b.cpu_rom_addr_i = 19'h00123;
        tick();
        chk("inflt_req", b.mem_req_o, 1);
        tick();
        rst_n = 0; b.cpu_req_i = 0;
        tick();
        chk("inrst_mem_req", b.mem_req_o, 0);
        chk("inrst_addr", b.mem_addr_o, 0);
        chk("inrst_acks", {b.cpu_ack_o, b.ppu_ack_o}, 0);
        chk("inrst_rdata", {b.cpu_rdata_o, b.ppu_rdata_o}, 0);
        chk("inrst_err", b.proto_err_o, 0);
        rst_n = 1; b.mem_rvalid_i = 1; b.mem_rdata_i = 8'h77;
        tick();
        chk("stray_err", b.proto_err_o, 1);
        chk("stray_no_ack", b.cpu_ack_o, 0);
        b.mem_rvalid_i = 0;
        tick();
        chk("stray_err_sticky", b.proto_err_o, 1);
        chk("stray_no_ack2", b.cpu_ack_o, 0);

        // Write to PRG ROM completes without touching memory
        b.cpu_req_i = 1; b.cpu_sel_ram_i = 0; b.cpu_we_i = 1; b.cpu_rom_addr_i = 19'h00456;
        tick();
        chk("romwr_ack", b.cpu_ack_o, 1);
        chk("romwr_no_mem", b.mem_req_o, 0);
        idle_inputs();
        tick();
        chk("romwr_ack_single", b.cpu_ack_o, 0);
        chk("romwr_no_mem2", b.mem_req_o, 0);

        // Simultaneous requests: round-robin alternates, priority favours PPU
        pair("pair0", 1'b0);
        pair("pair1", 1'b0);
        pair("pair2", 1'b0);

        // PRG RAM write to the top of the window; leaves CPU as last grant
        b.cpu_req_i = 1; b.cpu_sel_ram_i = 1; b.cpu_we_i = 1;
        b.cpu_ram_addr_i = 15'h7FFF; b.cpu_wdata_i = 8'h3C;
        tick();
        chk("ramwr_addr", b.mem_addr_o, 21'h187FFF);
        chk("ramwr_we", b.mem_we_o, 1);
        chk("ramwr_wdata", b.mem_wdata_o, 8'h3C);
        tick();
        chk("ramwr_ack", b.cpu_ack_o, 1);
        idle_inputs();
        tick();
        chk("ramwr_ack_single", b.cpu_ack_o, 0);

        pair("pair_after_cpu", 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
